// File: rtl/uart_regfile_ctrl.sv
// Command sequencer: unloads 18-bit UART packets, validates parity/address,
// writes the config regfile or returns a read response through the TX UART.
module uart_regfile_ctrl #(
  parameter int NUMREGS = 42
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data,
  output logic [17:0] tx_data,
  output logic        ld_tx_data,
  input  logic        tx_busy,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [7:0]  parity_err_cnt,
  output logic [7:0]  addr_err_cnt
);

  localparam logic [8:0] NUMREGS_W = 9'(NUMREGS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    TX_WAIT = 3'd4,
    TX_LOAD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] pkt_q, pkt_d;
  logic [17:0] tx_q, tx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  perr_q, perr_d;
  logic [7:0]  aerr_q, aerr_d;

  logic        pkt_par_ok;
  logic [7:0]  pkt_addr;
  logic [16:0] rsp_body;

  assign pkt_par_ok = ^pkt_q;
  assign pkt_addr   = pkt_q[16:9];
  assign rsp_body   = {addr_q, reg_rdata, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      perr_q  <= '0;
      aerr_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    perr_d      = perr_q;
    aerr_d      = aerr_q;
    uld_rx_data = 1'b0;
    reg_we      = 1'b0;
    ld_tx_data  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          uld_rx_data = 1'b1;
          pkt_d       = rx_data;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        // Parity is judged before the address: a corrupted address is not an address error.
        if (!pkt_par_ok) begin
          if (perr_q != 8'hff) perr_d = perr_q + 8'd1;
          state_d = IDLE;
        end else if ({1'b0, pkt_addr} >= NUMREGS_W) begin
          if (aerr_q != 8'hff) aerr_d = aerr_q + 8'd1;
          state_d = IDLE;
        end else begin
          addr_d  = pkt_addr;
          wdata_d = pkt_q[8:1];
          state_d = pkt_q[0] ? READ : WRITE;
        end
      end
      WRITE: begin
        reg_we  = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        tx_d    = {~^rsp_body, rsp_body};
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy) state_d = TX_LOAD;
      end
      TX_LOAD: begin
        // Held until the transmitter shows it has taken the word.
        ld_tx_data = 1'b1;
        if (tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign tx_data        = tx_q;
  assign reg_addr       = addr_q;
  assign reg_wdata      = wdata_q;
  assign parity_err_cnt = perr_q;
  assign addr_err_cnt   = aerr_q;

endmodule

// File: tb/tb_uart_regfile_ctrl.sv
// Randomized bench for uart_regfile_ctrl against a packet-level reference model.
module tb_uart_regfile_ctrl;

  localparam int NREG = 42;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [17:0] rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic [17:0] tx_data;
  logic        ld_tx_data;
  logic        tx_busy;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic [7:0]  parity_err_cnt;
  logic [7:0]  addr_err_cnt;

  uart_regfile_ctrl #(.NUMREGS(NREG)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
    .uld_rx_data(uld_rx_data), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_busy(tx_busy), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy), .parity_err_cnt(parity_err_cnt),
    .addr_err_cnt(addr_err_cnt)
  );

  always #5 clk = ~clk;

  // Environment regfile, written only by the DUT's strobe.
  logic [7:0] rf [0:255];
  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_wdata;
  assign reg_rdata = rf[reg_addr];

  // Reference model state.
  logic [7:0]  mdl [0:255];
  int          exp_perr, exp_aerr;
  logic [7:0]  exp_addr, exp_wdata;
  logic [17:0] exp_tx;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic [7:0] a, input logic [7:0] d,
                                     input logic rd, input logic bad);
    logic [17:0] body;
    logic        p;
    body = {1'b0, a, d, rd};
    p = ($countones(body) % 2 == 0);
    if (bad) p = ~p;
    return {p, a, d, rd};
  endfunction

  task automatic model_reset();
    exp_perr = 0; exp_aerr = 0; exp_addr = 0; exp_wdata = 0; exp_tx = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_perr"}, parity_err_cnt, exp_perr);
    check({tag, "_aerr"}, addr_err_cnt, exp_aerr);
    check({tag, "_addr"}, reg_addr, exp_addr);
    check({tag, "_wdata"}, reg_wdata, exp_wdata);
    check({tag, "_tx"}, tx_data, exp_tx);
  endtask

  // kind: 0 parity error, 1 address error, 2 write, 3 read.
  task automatic send_pkt(input logic [17:0] pkt, input int hold, input int ackd);
    int kind, c, we_n, we_c, ld_first, ld_last, ack_c, idle_c, extra_uld, exp_ld;
    bit done, tx_bad;
    logic [7:0] a, d;
    logic [17:0] body;
    a = pkt[16:9]; d = pkt[8:1];
    if ($countones(pkt) % 2 == 0) begin
      kind = 0; if (exp_perr < 255) exp_perr++;
    end else if (int'(a) >= NREG) begin
      kind = 1; if (exp_aerr < 255) exp_aerr++;
    end else begin
      exp_addr = a; exp_wdata = d;
      if (!pkt[0]) begin
        kind = 2; mdl[a] = d;
      end else begin
        kind = 3;
        body = {1'b0, a, mdl[a], 1'b1};
        exp_tx = body | (($countones(body) % 2 == 0) ? 18'h20000 : 18'h0);
      end
    end

    @(negedge clk);
    rx_data = pkt; rx_empty = 1'b0; tx_busy = (hold > 0);
    #1;
    check("uld_pulse", uld_rx_data, 1);
    check("busy_idle", busy, 0);
    @(negedge clk);
    rx_empty = 1'b1; rx_data = 18'($urandom);
    c = 1; we_n = 0; we_c = -1; ld_first = -1; ld_last = -1; ack_c = -1;
    idle_c = -1; extra_uld = 0; done = 0; tx_bad = 0;
    while (!done && c <= 400) begin
      if (ack_c >= 0) tx_busy = (c < ack_c + 3);
      else if (ld_first >= 0 && c >= ld_first + ackd) begin ack_c = c; tx_busy = 1'b1; end
      else tx_busy = (c < hold);
      #1;
      if (reg_we) begin
        we_n++; we_c = c;
        check("we_addr", reg_addr, a);
        check("we_wdata", reg_wdata, d);
      end
      if (ld_tx_data) begin
        if (ld_first < 0) ld_first = c;
        ld_last = c;
      end
      if (uld_rx_data) extra_uld++;
      if (kind == 3 && c >= 3 && tx_data !== exp_tx) tx_bad = 1;
      if (idle_c < 0 && !busy) idle_c = c;
      if (c >= 2 && !busy && !tx_busy) done = 1;
      else begin
        @(negedge clk); c++;
      end
    end
    if (!done) check("timeout", 1, 0);
    check("extra_uld", extra_uld, 0);
    if (kind == 2) begin
      check("we_count", we_n, 1);
      check("we_cycle", we_c, 2);
      check("wr_no_ld", ld_first, -1);
      check("wr_idle_cycle", idle_c, 3);
    end else if (kind == 3) begin
      exp_ld = (hold + 1 > 4) ? hold + 1 : 4;
      check("rd_no_we", we_n, 0);
      check("ld_first", ld_first, exp_ld);
      check("ld_last", ld_last, exp_ld + ackd);
      check("rd_idle_cycle", idle_c, exp_ld + ackd + 1);
      check("tx_stable", tx_bad, 0);
    end else begin
      check("err_no_we", we_n, 0);
      check("err_no_ld", ld_first, -1);
      check("err_idle_cycle", idle_c, 2);
    end
    check_state("post");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uld"}, uld_rx_data, 0);
    check({tag, "_ld"}, ld_tx_data, 0);
    check({tag, "_we"}, reg_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx"}, tx_data, 0);
    check({tag, "_addr"}, reg_addr, 0);
    check({tag, "_wdata"}, reg_wdata, 0);
    check({tag, "_perr"}, parity_err_cnt, 0);
    check({tag, "_aerr"}, addr_err_cnt, 0);
  endtask

  logic [7:0] ra, rd_v;
  int         hold, we_seen;
  bit         seen;

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf[i] = 8'($urandom);
      mdl[i] = rf[i];
    end
    reset_n = 1'b0; rx_data = '0; rx_empty = 1'b1; tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk); reset_n = 1'b1;

    // Directed vectors from the packet examples.
    send_pkt(18'h20356, 0, 1);
    send_pkt(18'h20201, 0, 2);
    check("tp_read_tx", tx_data, 18'h00357);
    send_pkt(18'h00356, 0, 1);
    check("tp_perr", parity_err_cnt, 1);
    send_pkt(mk(8'h2a, 8'h11, 1'b0, 1'b0), 0, 1);
    check("tp_aerr", addr_err_cnt, 1);
    send_pkt(mk(8'h29, 8'h5c, 1'b0, 1'b0), 0, 1);
    send_pkt(mk(8'h29, 8'h00, 1'b1, 1'b0), 50, 2);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 47));
      rd_v = 8'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 0;
      send_pkt(mk(ra, rd_v, 1'($urandom), ($urandom_range(0, 4) == 0)),
               hold, int'($urandom_range(1, 3)));
    end

    // Reset while in TX_LOAD.
    @(negedge clk);
    rx_data = mk(8'h05, 8'h00, 1'b1, 1'b0); rx_empty = 1'b0; tx_busy = 1'b0;
    @(negedge clk); rx_empty = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1 if (ld_tx_data) seen = 1; else @(negedge clk);
    end
    check("rst_ld_reached", seen, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    send_pkt(mk(8'h10, 8'hc3, 1'b0, 1'b0), 0, 1);
    send_pkt(mk(8'h10, 8'h00, 1'b1, 1'b0), 0, 1);

    // Reset while a write sits in DECODE: the write must be lost.
    @(negedge clk);
    rx_data = mk(8'h07, ~mdl[7], 1'b0, 1'b0); rx_empty = 1'b0;
    @(negedge clk); rx_empty = 1'b1;
    #1 check("decode_busy", busy, 1);
    reset_n = 1'b0;
    #1 check("decode_rst_busy", busy, 0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    we_seen = 0;
    repeat (4) begin
      @(negedge clk); #1 if (reg_we) we_seen++;
    end
    check("decode_rst_no_we", we_seen, 0);
    send_pkt(mk(8'h07, 8'h00, 1'b1, 1'b0), 0, 1);

    // Counter saturation.
    for (int i = 0; i < 260; i++)
      send_pkt(mk(8'($urandom_range(0, 41)), 8'($urandom), 1'($urandom), 1'b1), 0, 1);
    check("perr_sat", parity_err_cnt, 255);
    for (int i = 0; i < 260; i++)
      send_pkt(mk(8'($urandom_range(42, 255)), 8'($urandom), 1'($urandom), 1'b0), 0, 1);
    check("aerr_sat", addr_err_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_regfile_ctrl.md
# uart_regfile_ctrl

Command sequencer between the chip's UART receiver/transmitter and the config regfile inside the digital core. It unloads each 18-bit packet from the RX UART, checks parity and address, and then acts on it. A write strobes the regfile. A read fetches the register and queues a response packet into the TX UART. Error packets are counted and dropped.

## Interface
- NUMREGS, 42, number of implemented config registers; legal addresses 0..NUMREGS-1
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx_data  in  18  packet from uart_rx: [17] parity, [16:9] addr, [8:1] data, [0] wrb (0=write, 1=read)
- rx_empty  in  1  low = packet waiting in uart_rx
- uld_rx_data  out  1  one-cycle unload strobe to uart_rx
- tx_data  out  18  response packet to uart_tx, same field layout
- ld_tx_data  out  1  load request to uart_tx, held until tx_busy seen high
- tx_busy  in  1  high while uart_tx is shifting
- reg_addr  out  8  regfile address
- reg_wdata  out  8  regfile write data
- reg_we  out  1  one-cycle regfile write strobe
- reg_rdata  in  8  combinational regfile read of reg_addr
- busy  out  1  high in every state except IDLE
- parity_err_cnt  out  8  saturating count of dropped parity-error packets
- addr_err_cnt  out  8  saturating count of dropped out-of-range packets

## Operation
- Parity is odd over all 18 bits: a packet is good when the XOR of bits [17:0] is 1. Responses are generated with the same rule.
- The FSM has six states: IDLE, DECODE, WRITE, READ, TX_WAIT and TX_LOAD.
- IDLE: when rx_empty=0, latch rx_data into the packet register and pulse uld_rx_data for that cycle. Next state is DECODE.
- DECODE: rx_empty is ignored in this state. Checks are made in this order:
  - Bad parity: parity_err_cnt+1, saturating at 255. Go to IDLE.
  - Parity good but addr ≥ NUMREGS: addr_err_cnt+1, saturating at 255. Go to IDLE.
  - Parity and address good: drive reg_addr=addr and reg_wdata=data. If wrb=0 go to WRITE, else go to READ.
- WRITE: reg_we=1 for this single cycle, then go to IDLE. Writes produce no response packet.
- READ: build tx_data = {par, addr, reg_rdata, 1'b1}, with par chosen to make the total ones count odd. Go to TX_WAIT.
- TX_WAIT: stay while tx_busy=1. When tx_busy=0, go to TX_LOAD.
- TX_LOAD: ld_tx_data=1. When tx_busy=1 is sampled, drop ld_tx_data and go to IDLE.
- tx_data holds its value until the next READ. reg_addr and reg_wdata hold until the next good DECODE.
- Malformed packets never touch the regfile or the TX UART.

## Timing
- Reset values: uld_rx_data=0, ld_tx_data=0, reg_we=0, busy=0, tx_data=0, reg_addr=0, reg_wdata=0, both counters=0, state=IDLE.
- Write latency: rx_empty low sampled at edge N gives uld_rx_data high in cycle N. reg_we is high in cycle N+2. The controller can accept the next packet in cycle N+3.
- Read latency, TX idle: ld_tx_data rises in cycle N+4. It stays high through the cycle in which tx_busy is first sampled high.
- Read while TX busy: ld_tx_data is withheld until the first cycle after tx_busy falls.
- Back-to-back packets: only one packet is in flight. Later packets remain buffered in uart_rx and are unloaded in later IDLE cycles.
- Counter saturation: a counter already at 255 stays at 255.
- Reset mid-operation: asynchronous clear of every output and of the FSM.
  - An ld_tx_data that was asserted drops immediately.
  - A partially processed packet is discarded with no regfile write.

## Test plan
- Write addr 0x01, data 0xab: rx_data=0x20356 gives one uld pulse, then reg_we high for 1 cycle at N+2 with reg_addr=0x01 and reg_wdata=0xab. ld_tx_data stays 0.
- Read addr 0x01 with reg_rdata=0xab: rx_data=0x20201 gives ld_tx_data at N+4 and tx_data=0x00357.
- Parity error: rx_data=0x00356 gives parity_err_cnt=1, no reg_we, no ld_tx_data. 256 such packets leave the counter at 255.
- Bad address 0x2a (=42) with good parity gives addr_err_cnt=1 and no regfile or TX activity. Address 0x29 is accepted.
- Read while tx_busy is held high for 50 cycles: ld_tx_data stays low until the cycle after tx_busy falls, then follows the handshake. tx_data is stable throughout.
- Reset pulse while in TX_LOAD: all outputs go to their reset values asynchronously. After release, a new write completes normally.
